// File: rtl/hazard_unit.sv
// Pipeline hazard unit: load-use stall, taken-branch flush, and an optional
// long-latency (multiply) scoreboard enabled by defining HAZARD_UNIT_LONGOP_EN.
// Control outputs are combinational so a stall takes effect in the cycle the
// hazard is seen. During reset they are forced to the free-running values.
module hazard_unit #(
    parameter int unsigned LONG_LAT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] IF_ID_RegisterRS,
    input  logic [3:0] IF_ID_RegisterRT,
    input  logic       IF_ID_IsLongOp,
    input  logic       ID_EX_MemRead,
    input  logic [3:0] ID_EX_RegisterRT,
    input  logic       LongOpStart,
    input  logic [3:0] LongOpDest,
    input  logic       BranchTaken,
    output logic       PCWrite,
    output logic       IF_ID_Write,
    output logic       IF_ID_Flush,
    output logic       ID_EX_Flush,
    output logic       LongBusy,
    output logic       LongDone,
    output logic       ProtoErr
);

    localparam int unsigned RegW = 4;
    localparam int unsigned CntW = 4;
    localparam logic [CntW-1:0] LoadCnt = CntW'(LONG_LAT - 1);

    logic loadUseHazard;
    logic longStall;
    logic stall;
    logic branchFlush;

    // Load in EX whose (non-zero) destination feeds the instruction in ID
    assign loadUseHazard = ID_EX_MemRead
                        && (ID_EX_RegisterRT != RegW'(0))
                        && ((ID_EX_RegisterRT == IF_ID_RegisterRS)
                         || (ID_EX_RegisterRT == IF_ID_RegisterRT));

`ifdef HAZARD_UNIT_LONGOP_EN
    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } stateT;

    stateT           state;
    stateT           stateNext;
    logic [CntW-1:0] cnt;
    logic [CntW-1:0] cntNext;
    logic [RegW-1:0] pDest;
    logic [RegW-1:0] pDestNext;
    logic            protoErrQ;
    logic            protoErrNext;
    logic            longDoneC;

    // Long-op state register; reset abandons any op in flight
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            pDest     <= '0;
            protoErrQ <= 1'b0;
        end else begin
            state     <= stateNext;
            cnt       <= cntNext;
            pDest     <= pDestNext;
            protoErrQ <= protoErrNext;
        end
    end

    // Long-op next state, completion pulse and dependency stall
    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        pDestNext    = pDest;
        protoErrNext = protoErrQ;
        longDoneC    = 1'b0;
        longStall    = 1'b0;
        case (state)
            IDLE: begin
                if (LongOpStart) begin
                    stateNext = BUSY;
                    cntNext   = LoadCnt;
                    pDestNext = LongOpDest;
                end
            end
            BUSY: begin
                cntNext = cnt - CntW'(1);
                // A second start while busy is dropped and flagged
                if (LongOpStart) begin
                    protoErrNext = 1'b1;
                end
                if (cnt == CntW'(1)) begin
                    // Result is forwarded this cycle, so no stall
                    longDoneC = 1'b1;
                    stateNext = IDLE;
                end else begin
                    longStall = ((pDest != RegW'(0))
                                 && ((pDest == IF_ID_RegisterRS)
                                  || (pDest == IF_ID_RegisterRT)))
                             || IF_ID_IsLongOp;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    assign LongBusy = (state == BUSY);
    assign LongDone = longDoneC;
    assign ProtoErr = protoErrQ;
`else
    logic unusedLongOpInputs;

    // Long-op inputs have no effect when the scoreboard is compiled out
    assign unusedLongOpInputs = ^{clk, IF_ID_IsLongOp, LongOpStart, LongOpDest, LoadCnt};
    assign longStall = 1'b0;
    assign LongBusy  = 1'b0;
    assign LongDone  = 1'b0;
    assign ProtoErr  = 1'b0;
`endif

    // Branch flush overrides any stall; reset forces free-running controls
    assign stall       = rst_n && (loadUseHazard || longStall);
    assign branchFlush = rst_n && BranchTaken;

    assign PCWrite     = branchFlush || !stall;
    assign IF_ID_Write = branchFlush || !stall;
    assign IF_ID_Flush = branchFlush;
    assign ID_EX_Flush = branchFlush || stall;

endmodule

// File: doc/hazard_unit.md
HAZARD_UNIT -- requirements
Module: hazard_unit

Interface
REQ-001 SHALL have parameter LONG_LAT, default 4, latency in cycles of a long-latency (multiply) op; legal range 2..15.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-004 SHALL have port IF_ID_RegisterRS  input  4  source register A of instruction in ID.
REQ-005 SHALL have port IF_ID_RegisterRT  input  4  source register B of instruction in ID.
REQ-006 SHALL have port IF_ID_IsLongOp  input  1  instruction in ID is a long-latency op.
REQ-007 SHALL have port ID_EX_MemRead  input  1  instruction in EX is a load.
REQ-008 SHALL have port ID_EX_RegisterRT  input  4  destination of instruction in EX.
REQ-009 SHALL have port LongOpStart  input  1  one-cycle pulse: long op enters EX this cycle.
REQ-010 SHALL have port LongOpDest  input  4  destination register of that long op.
REQ-011 SHALL have port BranchTaken  input  1  branch resolved taken in EX.
REQ-012 SHALL have port PCWrite  output  1  PC update enable.
REQ-013 SHALL have port IF_ID_Write  output  1  IF/ID register update enable.
REQ-014 SHALL have port IF_ID_Flush  output  1  zero IF/ID register.
REQ-015 SHALL have port ID_EX_Flush  output  1  insert bubble into ID/EX.
REQ-016 SHALL have port LongBusy  output  1  long op in flight.
REQ-017 SHALL have port LongDone  output  1  one-cycle pulse, long op result available.
REQ-018 SHALL have port ProtoErr  output  1  sticky protocol-violation flag.

Function
REQ-019 Register 0 SHALL never cause a hazard; any comparison against a zero destination SHALL be false.
REQ-020 Load-use: ID_EX_MemRead=1 and ID_EX_RegisterRT equal to IF_ID_RegisterRS or IF_ID_RegisterRT SHALL assert stall in the same cycle (combinational).
REQ-021 Stall SHALL drive PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1, IF_ID_Flush=0.
REQ-022 States SHALL be IDLE and BUSY; BUSY holds a 4-bit down-counter CNT and a 4-bit pending destination PDEST.
REQ-023 In IDLE, LongOpStart=1 SHALL load CNT=LONG_LAT-1, PDEST=LongOpDest, and go BUSY next cycle.
REQ-024 In BUSY, CNT SHALL decrement each cycle; when CNT=1, LongDone SHALL pulse that cycle and state SHALL return to IDLE next edge.
REQ-025 LongBusy SHALL equal 1 exactly while in BUSY.
REQ-026 In BUSY, stall SHALL also assert when PDEST!=0 and PDEST matches IF_ID_RegisterRS or IF_ID_RegisterRT, or when IF_ID_IsLongOp=1, except in the LongDone cycle (result forwarded that cycle).
REQ-027 LongOpStart=1 while BUSY SHALL be ignored (no reload) and SHALL set ProtoErr=1 until reset.
REQ-028 BranchTaken=1 SHALL drive IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1, IF_ID_Write=1, overriding any stall.
REQ-029 BranchTaken SHALL NOT cancel a long op already in BUSY; it proceeds to LongDone.
REQ-030 With no stall and no branch: PCWrite=1, IF_ID_Write=1, both flushes 0.

Reset
REQ-031 rst_n=0 SHALL immediately force state IDLE, CNT=0, PDEST=0, ProtoErr=0, independent of clk.
REQ-032 During reset outputs SHALL be PCWrite=1, IF_ID_Write=1, IF_ID_Flush=0, ID_EX_Flush=0, LongBusy=0, LongDone=0, ProtoErr=0.
REQ-033 Reset mid long-op SHALL abandon it with no LongDone pulse.

Configuration
REQ-034 Macro HAZARD_UNIT_LONGOP_EN defined SHALL include the IDLE/BUSY machine, REQ-022..REQ-027 and REQ-033.
REQ-035 Without HAZARD_UNIT_LONGOP_EN, LongOpStart, LongOpDest, IF_ID_IsLongOp SHALL be ignored and LongBusy, LongDone, ProtoErr SHALL be constant 0; load-use and branch behaviour unchanged.

Verification
REQ-036 ID_EX_MemRead=1, ID_EX_RegisterRT=5, IF_ID_RegisterRT=5 -> same cycle PCWrite=0, IF_ID_Write=0, ID_EX_Flush=1.
REQ-037 ID_EX_MemRead=1, ID_EX_RegisterRT=0, IF_ID_RegisterRS=0 -> no stall.
REQ-038 LONG_LAT=4, LongOpStart with LongOpDest=7 at cycle 0, IF_ID_RegisterRS=7 held -> stall cycles 1-2, LongDone=1 and no stall cycle 3, LongBusy=0 cycle 4.
REQ-039 Load-use stall active and BranchTaken=1 same cycle -> IF_ID_Flush=1, ID_EX_Flush=1, PCWrite=1.
REQ-040 Second LongOpStart while BUSY -> CNT unchanged, ProtoErr=1 held until rst_n=0; rst_n=0 mid-BUSY -> LongBusy=0 immediately, no LongDone.
